// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the four clients and the round-robin arbiter.
// Clients drive en/req through master; the arbiter answers through slave.
interface rr_arbiter_4_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-client round-robin arbiter with global enable and a maximum-hold timeout.
// Grants are registered one-hot; every release is followed by one idle cycle.
module rr_arbiter_4 #(
  parameter int HOLD_MAX = 16
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter_4_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic       HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

  state_e     state_q,     state_d;
  logic [1:0] ptr_q,       ptr_d;
  logic [1:0] cur_q,       cur_d;
  logic [7:0] hold_cnt_q,  hold_cnt_d;
  logic [3:0] gnt_q,       gnt_d;
  logic [1:0] gnt_idx_q,   gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q,   timeout_d;

  logic [2:0] pick;
  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [3:0] cur_mask;
  logic       cur_req;
  logic       others_req;
  logic       hold_expired;

  // Rotating-priority search starting at p; result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [3:0] dec_2to4(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign pick         = rr_pick(bus.req, ptr_q);
  assign pick_vld     = pick[2];
  assign pick_idx     = pick[1:0];
  assign cur_mask     = dec_2to4(cur_q);
  assign cur_req      = |(bus.req & cur_mask);
  assign others_req   = |(bus.req & ~cur_mask);
  assign hold_expired = HOLD_EN && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d       = 4'b0000;
        gnt_valid_d = 1'b0;
        if (bus.en && pick_vld) begin
          state_d     = GRANT;
          gnt_d       = dec_2to4(pick_idx);
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          cur_d       = pick_idx;
          ptr_d       = pick_idx + 2'd1;
          hold_cnt_d  = 8'd0;
        end
      end

      GRANT: begin
        // A dropping request wins over an expiring hold: no timeout then.
        if (!cur_req) begin
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
        end else if (hold_expired && others_req) begin
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
          timeout_d   = 1'b1;
        end else begin
          hold_cnt_d  = sat_inc8(hold_cnt_q);
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = 4'b0000;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      cur_q       <= 2'd0;
      hold_cnt_q  <= 8'd0;
      gnt_q       <= 4'b0000;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios plus a random run against a
// cycle-level behavioural model of who owns the resource.
module tb_rr_arbiter_4;
  localparam int HM = 4;

  logic clk = 1'b0;
  logic rst_n;

  rr_arbiter_4_if b ();

  rr_arbiter_4 #(.HOLD_MAX(HM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: owner is the client holding the resource (-1 = nobody), nxt the
  // client with top priority, held the number of grant cycles so far.
  int m_owner;
  int m_nxt;
  int m_idx;
  int m_held;
  bit m_to;

  function automatic void m_reset();
    m_owner = -1;
    m_nxt   = 0;
    m_idx   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void m_step(input logic en_s, input logic [3:0] req_s);
    bit found;
    int c;
    bit others;
    m_to = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      if (en_s && req_s != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          c = (m_nxt + k) % 4;
          if (!found && req_s[c]) begin
            found   = 1'b1;
            m_owner = c;
            m_idx   = c;
            m_nxt   = (c + 1) % 4;
            m_held  = 1;
          end
        end
      end
    end else begin
      others = 1'b0;
      for (int k = 0; k < 4; k++)
        if (k != m_owner && req_s[k]) others = 1'b1;
      if (!req_s[m_owner]) begin
        m_owner = -1;
      end else if (HM != 0 && m_held == HM && others) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end
  endfunction

  function automatic logic [3:0] exp_gnt();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic tick();
    logic       e;
    logic [3:0] r;
    @(posedge clk);
    e = b.en;
    r = b.req;
    if (rst_n) m_step(e, r);
    else       m_reset();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    b.req = 4'b0000;
    m_reset();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b.en  = 1'b1;
    b.req = 4'b1111;
    m_reset();
    tick();
    tick();
    checks++;
    if (b.gnt !== 4'b0000 || b.gnt_valid !== 1'b0 || b.timeout !== 1'b0 || b.gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b v=%b to=%b idx=%0d want all zero",
               b.gnt, b.gnt_valid, b.timeout, b.gnt_idx);
    end
    b.req = 4'b0000;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b.gnt !== 4'b0000 || b.gnt_valid !== 1'b0 || b.timeout !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d got gnt=%b v=%b to=%b want zero",
                 i, b.gnt, b.gnt_valid, b.timeout);
      end
    end
  endtask

  task automatic test_single_client();
    b.en  = 1'b1;
    b.req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (b.gnt !== 4'b0010 || b.gnt_idx !== 2'd1 || b.gnt_valid !== 1'b1 || b.timeout !== 1'b0) begin
        errors++;
        $display("FAIL single_grant cyc %0d got gnt=%b idx=%0d v=%b to=%b want 0010/1/1/0",
                 i, b.gnt, b.gnt_idx, b.gnt_valid, b.timeout);
      end
    end
    b.req = 4'b0000;
    tick();
    checks++;
    if (b.gnt !== 4'b0000 || b.gnt_valid !== 1'b0 || b.timeout !== 1'b0 || b.gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL single_release got gnt=%b v=%b to=%b idx=%0d want 0000/0/0/1",
               b.gnt, b.gnt_valid, b.timeout, b.gnt_idx);
    end
  endtask

  task automatic test_round_robin();
    int age [4];
    int off [4];
    int order[$];
    logic [3:0] prev;
    do_reset();
    b.en  = 1'b1;
    b.req = 4'b1111;
    prev  = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      age[c] = 0;
      off[c] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (b.gnt !== exp_gnt() || b.timeout !== m_to) begin
        errors++;
        $display("FAIL rr_cycle %0d got gnt=%b to=%b want gnt=%b to=%b",
                 i, b.gnt, b.timeout, exp_gnt(), m_to);
      end
      if (prev == 4'b0000 && b.gnt != 4'b0000) order.push_back(int'(b.gnt_idx));
      prev = b.gnt;
      for (int c = 0; c < 4; c++) begin
        if (off[c] > 0) begin
          off[c]--;
          if (off[c] == 0) b.req[c] = 1'b1;
        end
        if (m_owner == c) begin
          age[c]++;
          if (age[c] == 2) begin
            b.req[c] = 1'b0;
            off[c]   = 1;
          end
        end else begin
          age[c] = 0;
        end
      end
    end
    checks++;
    if (order.size() < 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 ||
        order[3] != 3 || order[4] != 0) begin
      errors++;
      $display("FAIL rr_order got %p want 0,1,2,3,0", order);
    end
    b.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    b.en  = 1'b1;
    b.req = 4'b0100;
    tick();
    checks++;
    if (b.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL to_first_grant got %b want 0100", b.gnt);
    end
    b.req = 4'b0101;
    cnt   = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (b.gnt != 4'b0100) break;
      cnt++;
    end
    checks++;
    if (cnt != HM || b.gnt !== 4'b0000 || b.timeout !== 1'b1 || b.gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_forced len=%0d gnt=%b to=%b v=%b want len=%0d gnt=0000 to=1 v=0",
               cnt, b.gnt, b.timeout, b.gnt_valid, HM);
    end
    tick();
    checks++;
    if (b.gnt !== 4'b0001 || b.timeout !== 1'b0 || b.gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL to_next_grant got gnt=%b to=%b idx=%0d want 0001/0/0",
               b.gnt, b.timeout, b.gnt_idx);
    end
    b.req = 4'b0000;
    tick();
    tick();
    b.req = 4'b0100;
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if (b.gnt !== 4'b0100 || b.timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_alone_hold cyc %0d got gnt=%b to=%b want 0100/0",
                 i, b.gnt, b.timeout);
      end
    end
    b.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_enable();
    do_reset();
    b.en  = 1'b0;
    b.req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b.gnt !== 4'b0000 || b.gnt_valid !== 1'b0) begin
        errors++;
        $display("FAIL en_gated cyc %0d got gnt=%b v=%b want 0000/0", i, b.gnt, b.gnt_valid);
      end
    end
    b.en = 1'b1;
    tick();
    checks++;
    if (b.gnt !== 4'b1000 || b.gnt_idx !== 2'd3) begin
      errors++;
      $display("FAIL en_grant got gnt=%b idx=%0d want 1000/3", b.gnt, b.gnt_idx);
    end
    b.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (b.gnt !== 4'b1000) begin
        errors++;
        $display("FAIL en_drop_hold cyc %0d got gnt=%b want 1000", i, b.gnt);
      end
    end
    b.req = 4'b0000;
    tick();
    checks++;
    if (b.gnt !== 4'b0000 || b.timeout !== 1'b0) begin
      errors++;
      $display("FAIL en_release got gnt=%b to=%b want 0000/0", b.gnt, b.timeout);
    end
    b.en = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    b.en  = 1'b1;
    b.req = 4'b0100;
    tick();
    checks++;
    if (b.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL ar_pre_grant got %b want 0100", b.gnt);
    end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (b.gnt !== 4'b0000 || b.gnt_valid !== 1'b0 || b.timeout !== 1'b0) begin
      errors++;
      $display("FAIL ar_immediate got gnt=%b v=%b to=%b want zero",
               b.gnt, b.gnt_valid, b.timeout);
    end
    #2;
    rst_n = 1'b1;
    b.req = 4'b0101;
    tick();
    checks++;
    if (b.gnt !== 4'b0001 || b.gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL ar_ptr_restart got gnt=%b idx=%0d want 0001/0", b.gnt, b.gnt_idx);
    end
    b.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_random();
    int n_to;
    int n_gr;
    logic [3:0] prev;
    do_reset();
    n_to = 0;
    n_gr = 0;
    prev = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 5) == 0) b.req[k] = ~b.req[k];
      b.en = ($urandom_range(0, 9) != 0);
      tick();
      checks++;
      if (b.gnt !== exp_gnt() || b.gnt_idx !== 2'(m_idx) ||
          b.gnt_valid !== (m_owner >= 0) || b.timeout !== m_to) begin
        errors++;
        $display("FAIL rand cyc %0d got gnt=%b idx=%0d v=%b to=%b want gnt=%b idx=%0d v=%b to=%b",
                 i, b.gnt, b.gnt_idx, b.gnt_valid, b.timeout,
                 exp_gnt(), m_idx, (m_owner >= 0), m_to);
      end
      checks++;
      if ($countones(b.gnt) > 1 || b.gnt_valid !== (b.gnt != 4'b0000)) begin
        errors++;
        $display("FAIL rand_onehot cyc %0d got gnt=%b v=%b want one-hot with v=|gnt",
                 i, b.gnt, b.gnt_valid);
      end
      if (b.timeout === 1'b1) n_to++;
      if (prev == 4'b0000 && b.gnt != 4'b0000) n_gr++;
      prev = b.gnt;
    end
    $display("random run: %0d grants, %0d timeouts", n_gr, n_to);
  endtask

  initial begin
    b.en  = 1'b0;
    b.req = 4'b0000;
    rst_n = 1'b0;
    m_reset();
    test_reset();
    test_single_client();
    test_round_robin();
    test_timeout();
    test_enable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares one resource among four clients and drives a one-hot grant vector, the same select pattern our 2-to-4 decoder produces. It sits in front of the shared resource. It owns the decision of who gets access, how long they keep it, and in which order waiting clients are served. It adds fairness, a global enable and a maximum-hold timeout on top of plain decoding.

## Interface
- HOLD_MAX, 16: maximum consecutive grant cycles while another client is waiting; 0 disables the timeout; legal range 0..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; when low, no new grant is issued.
- req  input  4  request per client; the client holds it high for as long as it needs the resource.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- gnt_idx  output  2  binary index of the current or most recent grantee, registered.
- gnt_valid  output  1  high when gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- State machine: IDLE, GRANT.
- Internal registers:
  - ptr (2 bits): highest-priority client.
  - hold_cnt (8 bits).
  - cur (2 bits): current grantee.
- IDLE:
  - If en=1 and req≠0, select the first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: gnt=1<<sel, gnt_idx=sel, gnt_valid=1, cur=sel, ptr=sel+1 (mod 4, wraps 3→0), hold_cnt=0, go to GRANT.
  - If en=0 or req=0, stay in IDLE with outputs at zero. gnt_idx keeps its last value.
- GRANT:
  - Normal release: req[cur]=0 is sampled. On the next edge gnt=0, gnt_valid=0, go to IDLE. timeout stays 0.
  - Forced release: HOLD_MAX≠0, hold_cnt==HOLD_MAX-1, req[cur]=1, and at least one other req bit is set. On the next edge gnt=0, gnt_valid=0, timeout=1 for that cycle, go to IDLE.
  - Otherwise: hold the grant. hold_cnt increments and saturates at 255.
  - If no other client is waiting, the grant continues past HOLD_MAX with no timeout.
  - If normal and forced release conditions coincide (req[cur] drops in the HOLD_MAX-1 cycle), it is a normal release with no timeout.
- en only gates new grants. Dropping en during GRANT does not revoke the grant; normal and forced release still apply.
- ptr always points past the last grantee, so a released or timed-out client has lowest priority in the next arbitration.
- At most one gnt bit is ever high. gnt_valid equals |gnt at all times.
- Requests that drop before being granted are simply lost; the arbiter keeps no request memory.

## Timing
- Reset (asynchronous, immediate): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, cur=0, state IDLE.
- Reset asserted mid-grant clears gnt in the same instant, without waiting for a clock edge.
- After rst_n deasserts, the first edge evaluates IDLE normally.
- Grant latency: req sampled high in IDLE at edge N gives gnt high after edge N+1 (one cycle).
- Release latency: req[cur] sampled low at edge M gives gnt low after edge M+1.
- One mandatory dead cycle (gnt=0) follows every release, normal or forced. The next grant appears at the earliest one cycle after that.
- Forced grant length is exactly HOLD_MAX cycles of gnt high.
- The timeout pulse coincides with the first gnt=0 cycle.
- Fair service with all four requesting and holding the full HOLD_MAX each: every client is served within 3·(HOLD_MAX+1) cycles of its turn arising.

## Test plan
- Reset/idle: hold rst_n=0, drive req=4'b1111 → gnt=0, gnt_valid=0, timeout=0. Release rst_n with req=0 → outputs stay 0.
- Single client: en=1, req=4'b0010 held 5 cycles then dropped → gnt=4'b0010, gnt_idx=1 from one cycle after req rises for 5 cycles, then gnt=0. No timeout.
- Round-robin order: after reset, req=4'b1111. Each client drops its req 2 cycles after its own grant and re-asserts it 1 cycle later → grant order 0,1,2,3,0. Each grant is separated by one gnt=0 cycle, and ptr wraps 3→0.
- Timeout: HOLD_MAX=4, req[2] held continuously, req[0] raised during grant → gnt=4'b0100 for exactly 4 cycles, then a timeout pulse with gnt=0, then gnt=4'b0001. Repeat with req[0] low → the grant to client 2 persists for 20+ cycles with no timeout.
- Enable gating: en=0, req=4'b1000 → no grant. Raise en → gnt=4'b1000 one cycle later. Drop en mid-grant → the grant holds until req[3] drops.
- Async reset mid-grant: while gnt=4'b0100, pulse rst_n low between clock edges → gnt, gnt_valid and timeout go to 0 immediately. After release, req=4'b0101 → client 0 is granted first (ptr back at 0).
